// File: rtl/gf_sram_bridge_pkg.sv
// Shared types and default sizes for the GF180 SRAM management bridge.
package gf_sram_bridge_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_ADDR_BITS = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE
    } state_t;

    typedef enum logic {
        OWN_MGMT,
        OWN_FABRIC
    } owner_t;

endpackage

// File: rtl/gf_sram_mgmt_bridge.sv
// Arbitrates the GF180 SRAM macro between a management valid/ready port and the fabric pins.
// Define GF_SRAM_BRIDGE_LOCK_EN to make fabric ownership sticky until reset.
module gf_sram_mgmt_bridge
    import gf_sram_bridge_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                 UserCLK,
    input  logic                 resetn,
    input  logic                 CONFIGURED_top,
    input  logic                 CEN_SRAM,
    input  logic                 GWEN_SRAM,
    input  logic [WIDTH-1:0]     WEN_SRAM,
    input  logic [ADDR_BITS-1:0] A_SRAM,
    input  logic [WIDTH-1:0]     D_SRAM,
    output logic [WIDTH-1:0]     Q_SRAM,
    input  logic                 mgmt_valid,
    output logic                 mgmt_ready,
    input  logic                 mgmt_we,
    input  logic [ADDR_BITS-1:0] mgmt_addr,
    input  logic [WIDTH-1:0]     mgmt_wdata,
    output logic                 mgmt_rvalid,
    output logic [WIDTH-1:0]     mgmt_rdata,
    output logic                 CEN,
    output logic                 GWEN,
    output logic [WIDTH-1:0]     WEN,
    output logic [ADDR_BITS-1:0] A,
    output logic [WIDTH-1:0]     D,
    input  logic [WIDTH-1:0]     Q
);

    state_t                state_reg, state_next;
    owner_t                owner_reg, owner_next;
    logic                  we_reg;
    logic [ADDR_BITS-1:0]  a_reg;
    logic [WIDTH-1:0]      d_reg;
    logic [WIDTH-1:0]      rdata_reg;
    logic                  rvalid_reg;
    logic                  accept;

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            owner_reg <= OWN_MGMT;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
        end
    end

    // Ownership only moves in IDLE, so an in-flight transaction always completes first.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        mgmt_ready = (state_reg == ST_IDLE) && (owner_reg == OWN_MGMT) && !CONFIGURED_top;
        accept     = mgmt_valid && mgmt_ready;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ISSUE;
                end else if (owner_reg == OWN_MGMT && CONFIGURED_top) begin
                    owner_next = OWN_FABRIC;
                end
`ifndef GF_SRAM_BRIDGE_LOCK_EN
                else if (owner_reg == OWN_FABRIC && !CONFIGURED_top) begin
                    owner_next = OWN_MGMT;
                end
`endif
            end
            ST_ISSUE:   state_next = we_reg ? ST_IDLE : ST_CAPTURE;
            ST_CAPTURE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            we_reg     <= 1'b0;
            a_reg      <= '0;
            d_reg      <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            if (accept) begin
                we_reg <= mgmt_we;
                a_reg  <= mgmt_addr;
                d_reg  <= mgmt_wdata;
            end
            rvalid_reg <= (state_reg == ST_CAPTURE);
            if (state_reg == ST_CAPTURE) begin
                rdata_reg <= Q;
            end
        end
    end

    assign mgmt_rvalid = rvalid_reg;
    assign mgmt_rdata  = rdata_reg;

    // Fabric mode is a pure combinational pass-through; the macro's read latency is seen unchanged.
    always_comb begin
        if (owner_reg == OWN_FABRIC) begin
            CEN    = CEN_SRAM;
            GWEN   = GWEN_SRAM;
            WEN    = WEN_SRAM;
            A      = A_SRAM;
            D      = D_SRAM;
            Q_SRAM = Q;
        end else begin
            CEN    = (state_reg != ST_ISSUE);
            GWEN   = !((state_reg == ST_ISSUE) && we_reg);
            WEN    = {WIDTH{GWEN}};
            A      = a_reg;
            D      = d_reg;
            Q_SRAM = '0;
        end
    end

endmodule

// File: tb/tb_gf_sram_mgmt_bridge.sv
// Self-checking bench for gf_sram_mgmt_bridge: behavioural macro plus an array-based reference memory.
module tb_gf_sram_mgmt_bridge;

    logic       UserCLK = 1'b0;
    logic       resetn;
    logic       CONFIGURED_top;
    logic       CEN_SRAM, GWEN_SRAM;
    logic [7:0] WEN_SRAM;
    logic [8:0] A_SRAM;
    logic [7:0] D_SRAM;
    logic [7:0] Q_SRAM;
    logic       mgmt_valid, mgmt_ready, mgmt_we;
    logic [8:0] mgmt_addr;
    logic [7:0] mgmt_wdata;
    logic       mgmt_rvalid;
    logic [7:0] mgmt_rdata;
    logic       CEN, GWEN;
    logic [7:0] WEN;
    logic [8:0] A;
    logic [7:0] D;
    logic [7:0] q_macro;

    int checks = 0;
    int errors = 0;

    logic [7:0] macro_mem [512];
    logic [7:0] ref_mem   [512];

    always #5 UserCLK = ~UserCLK;

    gf_sram_mgmt_bridge #(.WIDTH(8), .ADDR_BITS(9)) dut (
        .UserCLK(UserCLK), .resetn(resetn), .CONFIGURED_top(CONFIGURED_top),
        .CEN_SRAM(CEN_SRAM), .GWEN_SRAM(GWEN_SRAM), .WEN_SRAM(WEN_SRAM),
        .A_SRAM(A_SRAM), .D_SRAM(D_SRAM), .Q_SRAM(Q_SRAM),
        .mgmt_valid(mgmt_valid), .mgmt_ready(mgmt_ready), .mgmt_we(mgmt_we),
        .mgmt_addr(mgmt_addr), .mgmt_wdata(mgmt_wdata),
        .mgmt_rvalid(mgmt_rvalid), .mgmt_rdata(mgmt_rdata),
        .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .A(A), .D(D), .Q(q_macro)
    );

    // Behavioural GF180 macro: synchronous, per-bit active-low write mask, 1-cycle read.
    always @(posedge UserCLK) begin
        if (!CEN) begin
            if (!GWEN) begin
                for (int b = 0; b < 8; b++)
                    if (!WEN[b]) macro_mem[A][b] <= D[b];
            end else begin
                q_macro <= macro_mem[A];
            end
        end
    end

    task automatic mgmt_issue(input logic we, input logic [8:0] addr, input logic [7:0] wd,
                              output bit ok);
        @(negedge UserCLK);
        mgmt_valid = 1'b1; mgmt_we = we; mgmt_addr = addr; mgmt_wdata = wd;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            #1;
            if (mgmt_ready) begin
                @(posedge UserCLK);
                ok = 1'b1;
            end else begin
                @(negedge UserCLK);
            end
        end
        #1;
        mgmt_valid = 1'b0;
    endtask

    task automatic wait_rvalid(output bit got, output int cyc, output logic [7:0] data);
        got = 1'b0; cyc = -1; data = '0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(posedge UserCLK); #1;
            if (mgmt_rvalid) begin
                got = 1'b1; cyc = i; data = mgmt_rdata;
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; CONFIGURED_top = 1'b0;
        CEN_SRAM = 1'b0; GWEN_SRAM = 1'b0; WEN_SRAM = 8'h00; A_SRAM = 9'h155; D_SRAM = 8'h77;
        mgmt_valid = 1'b0; mgmt_we = 1'b0; mgmt_addr = '0; mgmt_wdata = '0;
        repeat (2) @(posedge UserCLK);
        #1;
        checks++;
        if (CEN !== 1'b1 || GWEN !== 1'b1 || WEN !== 8'hFF || A !== 9'h000 || D !== 8'h00) begin
            errors++;
            $display("FAIL reset_pins got CEN=%b GWEN=%b WEN=%h A=%h D=%h want 1 1 ff 000 00",
                     CEN, GWEN, WEN, A, D);
        end
        checks++;
        if (mgmt_ready !== 1'b1 || mgmt_rvalid !== 1'b0 || mgmt_rdata !== 8'h00 || Q_SRAM !== 8'h00) begin
            errors++;
            $display("FAIL reset_mgmt got ready=%b rvalid=%b rdata=%h Q_SRAM=%h want 1 0 00 00",
                     mgmt_ready, mgmt_rvalid, mgmt_rdata, Q_SRAM);
        end
        CONFIGURED_top = 1'b1; #1;
        checks++;
        if (mgmt_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_cfg got %b want 0", mgmt_ready);
        end
        CONFIGURED_top = 1'b0; CEN_SRAM = 1'b1; GWEN_SRAM = 1'b1; WEN_SRAM = 8'hFF;
        @(negedge UserCLK);
        resetn = 1'b1;
        $display("reset released");
    endtask

    task automatic test_mgmt_write;
        bit ok;
        mgmt_issue(1'b1, 9'h1FF, 8'hA5, ok);
        ref_mem[9'h1FF] = 8'hA5;
        checks++;
        if (!ok || CEN !== 1'b0 || GWEN !== 1'b0 || WEN !== 8'h00 || A !== 9'h1FF || D !== 8'hA5) begin
            errors++;
            $display("FAIL write_issue got ok=%0d CEN=%b GWEN=%b WEN=%h A=%h D=%h want 1 0 0 00 1ff a5",
                     ok, CEN, GWEN, WEN, A, D);
        end
        checks++;
        if (mgmt_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_busy_ready got %b want 0", mgmt_ready);
        end
        @(posedge UserCLK); #1;
        checks++;
        if (CEN !== 1'b1 || GWEN !== 1'b1 || WEN !== 8'hFF || mgmt_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_done got CEN=%b GWEN=%b WEN=%h ready=%b want 1 1 ff 1",
                     CEN, GWEN, WEN, mgmt_ready);
        end
        $display("mgmt write a5 @ 1ff");
    endtask

    task automatic test_mgmt_read;
        bit ok, got;
        int cyc;
        logic [7:0] data;
        mgmt_issue(1'b0, 9'h1FF, 8'h00, ok);
        checks++;
        if (!ok || CEN !== 1'b0 || GWEN !== 1'b1 || WEN !== 8'hFF || A !== 9'h1FF || Q_SRAM !== 8'h00) begin
            errors++;
            $display("FAIL read_issue got ok=%0d CEN=%b GWEN=%b WEN=%h A=%h Q_SRAM=%h want 1 0 1 ff 1ff 00",
                     ok, CEN, GWEN, WEN, A, Q_SRAM);
        end
        wait_rvalid(got, cyc, data);
        checks++;
        if (!got || cyc != 1 || data !== ref_mem[9'h1FF] || Q_SRAM !== 8'h00 || mgmt_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_data got got=%0d cyc=%0d data=%h Q_SRAM=%h ready=%b want 1 1 %h 00 1",
                     got, cyc, data, Q_SRAM, mgmt_ready, ref_mem[9'h1FF]);
        end
        @(posedge UserCLK); #1;
        checks++;
        if (mgmt_rvalid !== 1'b0 || mgmt_rdata !== ref_mem[9'h1FF]) begin
            errors++;
            $display("FAIL read_strobe_len got rvalid=%b rdata=%h want 0 %h",
                     mgmt_rvalid, mgmt_rdata, ref_mem[9'h1FF]);
        end
        $display("mgmt read @ 1ff -> %h", data);
    endtask

    task automatic test_random_mgmt;
        bit ok, got;
        int cyc;
        logic [7:0] data, wd;
        logic [8:0] addr;
        for (int i = 0; i < 16; i++) begin
            wd = 8'($urandom);
            mgmt_issue(1'b1, 9'h100 + 9'(i), wd, ok);
            ref_mem[9'h100 + 9'(i)] = wd;
        end
        for (int n = 0; n < 30; n++) begin
            addr = 9'h100 + 9'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                wd = 8'($urandom);
                mgmt_issue(1'b1, addr, wd, ok);
                ref_mem[addr] = wd;
                $display("rand write %h @ %h", wd, addr);
            end else begin
                mgmt_issue(1'b0, addr, 8'h00, ok);
                wait_rvalid(got, cyc, data);
                checks++;
                if (!ok || !got || cyc != 1 || data !== ref_mem[addr]) begin
                    errors++;
                    $display("FAIL rand_read @%h got ok=%0d got=%0d cyc=%0d data=%h want 1 1 1 %h",
                             addr, ok, got, cyc, data, ref_mem[addr]);
                end else begin
                    $display("rand read @ %h -> %h", addr, data);
                end
            end
        end
    endtask

    task automatic test_config_mid_read;
        bit ok, got;
        int cyc;
        logic [7:0] data;
        mgmt_issue(1'b0, 9'h1FF, 8'h00, ok);
        CONFIGURED_top = 1'b1;
        CEN_SRAM = 1'b0; GWEN_SRAM = 1'b1; WEN_SRAM = 8'hFF; A_SRAM = 9'h0AA; D_SRAM = 8'h11;
        #1;
        checks++;
        if (!ok || mgmt_ready !== 1'b0 || A !== 9'h1FF || CEN !== 1'b0) begin
            errors++;
            $display("FAIL cfg_rise_inflight got ok=%0d ready=%b A=%h CEN=%b want 1 0 1ff 0",
                     ok, mgmt_ready, A, CEN);
        end
        wait_rvalid(got, cyc, data);
        checks++;
        if (!got || cyc != 1 || data !== ref_mem[9'h1FF]) begin
            errors++;
            $display("FAIL cfg_rise_rdata got got=%0d cyc=%0d data=%h want 1 1 %h",
                     got, cyc, data, ref_mem[9'h1FF]);
        end
        checks++;
        if (CEN !== 1'b1 || A !== 9'h1FF || mgmt_ready !== 1'b0) begin
            errors++;
            $display("FAIL cfg_owner_still_mgmt got CEN=%b A=%h ready=%b want 1 1ff 0", CEN, A, mgmt_ready);
        end
        @(posedge UserCLK); #1;
        checks++;
        if (CEN !== 1'b0 || A !== 9'h0AA || D !== 8'h11) begin
            errors++;
            $display("FAIL cfg_handover got CEN=%b A=%h D=%h want 0 0aa 11", CEN, A, D);
        end
        @(negedge UserCLK);
        CEN_SRAM = 1'b1;
        $display("handover to fabric after in-flight read");
    endtask

    task automatic test_fabric;
        logic [8:0] addr;
        logic [7:0] wd, mask;
        @(negedge UserCLK);
        mgmt_valid = 1'b1; mgmt_we = 1'b1; mgmt_addr = 9'h000; mgmt_wdata = 8'hEE;
        CEN_SRAM = 1'b0; GWEN_SRAM = 1'b0; WEN_SRAM = 8'h00; A_SRAM = 9'h000; D_SRAM = 8'h3C;
        #1;
        checks++;
        if (CEN !== 1'b0 || GWEN !== 1'b0 || WEN !== 8'h00 || A !== 9'h000 || D !== 8'h3C || mgmt_ready !== 1'b0) begin
            errors++;
            $display("FAIL fabric_write_pins got CEN=%b GWEN=%b WEN=%h A=%h D=%h ready=%b want 0 0 00 000 3c 0",
                     CEN, GWEN, WEN, A, D, mgmt_ready);
        end
        @(posedge UserCLK);
        ref_mem[9'h000] = 8'h3C;
        @(negedge UserCLK);
        GWEN_SRAM = 1'b1; WEN_SRAM = 8'hFF;
        @(posedge UserCLK); #1;
        checks++;
        if (Q_SRAM !== 8'h3C || mgmt_ready !== 1'b0) begin
            errors++;
            $display("FAIL fabric_read got Q_SRAM=%h ready=%b want 3c 0", Q_SRAM, mgmt_ready);
        end
        $display("fabric write/read 3c @ 000 -> %h", Q_SRAM);
        for (int i = 1; i < 16; i++) begin
            @(negedge UserCLK);
            GWEN_SRAM = 1'b0; WEN_SRAM = 8'h00; A_SRAM = 9'(i); D_SRAM = 8'($urandom);
            @(posedge UserCLK);
            ref_mem[9'(i)] = D_SRAM;
        end
        for (int n = 0; n < 24; n++) begin
            @(negedge UserCLK);
            addr = 9'($urandom_range(1, 15));
            A_SRAM = addr;
            if ($urandom_range(0, 1) == 1) begin
                wd = 8'($urandom); mask = 8'($urandom);
                GWEN_SRAM = 1'b0; WEN_SRAM = mask; D_SRAM = wd;
                #1;
                checks++;
                if (WEN !== mask || D !== wd || A !== addr || GWEN !== 1'b0) begin
                    errors++;
                    $display("FAIL fabric_mirror got WEN=%h D=%h A=%h GWEN=%b want %h %h %h 0",
                             WEN, D, A, GWEN, mask, wd, addr);
                end
                @(posedge UserCLK);
                ref_mem[addr] = (ref_mem[addr] & mask) | (wd & ~mask);
                $display("fabric write %h mask %h @ %h", wd, mask, addr);
            end else begin
                GWEN_SRAM = 1'b1; WEN_SRAM = 8'hFF;
                @(posedge UserCLK); #1;
                checks++;
                if (Q_SRAM !== ref_mem[addr] || mgmt_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL fabric_rand_read @%h got Q_SRAM=%h ready=%b want %h 0",
                             addr, Q_SRAM, mgmt_ready, ref_mem[addr]);
                end else begin
                    $display("fabric read @ %h -> %h", addr, Q_SRAM);
                end
            end
        end
        @(negedge UserCLK);
        CEN_SRAM = 1'b1; GWEN_SRAM = 1'b1; WEN_SRAM = 8'hFF; mgmt_valid = 1'b0;
    endtask

    task automatic test_unconfigure;
        bit ok, got;
        int cyc;
        logic [7:0] data;
        @(negedge UserCLK);
        CONFIGURED_top = 1'b0;
        #1;
        checks++;
        if (mgmt_ready !== 1'b0) begin
            errors++;
            $display("FAIL uncfg_same_cycle got ready=%b want 0", mgmt_ready);
        end
`ifdef GF_SRAM_BRIDGE_LOCK_EN
        for (int i = 0; i < 5; i++) begin
            @(posedge UserCLK); #1;
            checks++;
            if (mgmt_ready !== 1'b0) begin
                errors++;
                $display("FAIL lock_ready cycle %0d got %b want 0", i, mgmt_ready);
            end
        end
        @(negedge UserCLK);
        resetn = 1'b0;
        @(negedge UserCLK);
        resetn = 1'b1;
        #1;
`else
        @(posedge UserCLK); #1;
`endif
        checks++;
        if (mgmt_ready !== 1'b1) begin
            errors++;
            $display("FAIL uncfg_ready_back got %b want 1", mgmt_ready);
        end
        mgmt_issue(1'b0, 9'h000, 8'h00, ok);
        wait_rvalid(got, cyc, data);
        checks++;
        if (!ok || !got || data !== ref_mem[9'h000]) begin
            errors++;
            $display("FAIL uncfg_read got ok=%0d got=%0d data=%h want 1 1 %h", ok, got, data, ref_mem[9'h000]);
        end
        $display("mgmt read @ 000 after unconfigure -> %h", data);
    endtask

    task automatic test_reset_mid_txn;
        bit ok, got;
        int cyc;
        logic [7:0] data;
        mgmt_issue(1'b1, 9'h100, ~ref_mem[9'h100], ok);
        checks++;
        if (!ok || CEN !== 1'b0) begin
            errors++;
            $display("FAIL rst_write_issue got ok=%0d CEN=%b want 1 0", ok, CEN);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (CEN !== 1'b1 || GWEN !== 1'b1 || WEN !== 8'hFF || A !== 9'h000 || D !== 8'h00 ||
            mgmt_ready !== 1'b1 || mgmt_rvalid !== 1'b0 || mgmt_rdata !== 8'h00) begin
            errors++;
            $display("FAIL rst_async got CEN=%b GWEN=%b WEN=%h A=%h D=%h ready=%b rvalid=%b rdata=%h want 1 1 ff 000 00 1 0 00",
                     CEN, GWEN, WEN, A, D, mgmt_ready, mgmt_rvalid, mgmt_rdata);
        end
        @(negedge UserCLK);
        resetn = 1'b1;
        mgmt_issue(1'b0, 9'h100, 8'h00, ok);
        wait_rvalid(got, cyc, data);
        checks++;
        if (!got || data !== ref_mem[9'h100]) begin
            errors++;
            $display("FAIL rst_write_aborted got got=%0d data=%h want 1 %h", got, data, ref_mem[9'h100]);
        end
        mgmt_issue(1'b0, 9'h101, 8'h00, ok);
        resetn = 1'b0;
        @(negedge UserCLK);
        resetn = 1'b1;
        wait_rvalid(got, cyc, data);
        checks++;
        if (got || mgmt_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_read_no_rvalid got rvalid_seen=%0d ready=%b want 0 1", got, mgmt_ready);
        end
        $display("reset mid-transaction checks done");
    endtask

    initial begin
        test_reset();
        test_mgmt_write();
        test_mgmt_read();
        test_random_mgmt();
        test_config_mid_read();
        test_fabric();
        test_unconfigure();
        test_reset_mid_txn();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
